// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: mode encodings shared by ff_bank and ff_cell.
package ff_bank_pkg;
   typedef enum logic [1:0] {
      MODE_SR = 2'd0,
      MODE_JK = 2'd1,
      MODE_D  = 2'd2,
      MODE_T  = 2'd3
   } mode_t;
endpackage

// File: rtl/ff_cell.sv
// ff_cell: one SR/JK/D/T flip-flop channel with parallel load and illegal-SR detect.
module ff_cell
   import ff_bank_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  mode_t mode,
   input  logic  a,
   input  logic  b,
   input  logic  ld,
   input  logic  ld_data,
   output logic  q,
   output logic  ill,
   output logic  ill_nxt
);
   logic nxt;
   // a==b in JK: a=0 holds (q^0), a=1 toggles (q^1)
   always_comb begin
      nxt     = ld ? ld_data :
                !en ? q :
                mode == MODE_SR ? (a ^ b ? a : q) :
                mode == MODE_JK ? (a ^ b ? a : q ^ a) :
                mode == MODE_D  ? a : q ^ a;
      ill_nxt = ~ld & en & (mode == MODE_SR) & a & b;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q   <= 1'b0;
         ill <= 1'b0;
      end else begin
         q   <= nxt;
         ill <= ill_nxt;
      end
endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH independent mode-selectable flip-flops with sticky illegal flag.
// Define FF_BANK_ERR_CNT_EN to add the saturating err_cnt illegal-cycle counter.
module ff_bank
   import ff_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] illegal_mask,
   output logic             illegal
`ifdef FF_BANK_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);
   logic [WIDTH-1:0] ill_nxt;
   logic             ev;
   assign qbar = ~q;
   assign ev   = |ill_nxt;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .mode    (mode_t'(mode)),
         .a       (a[i]),
         .b       (b[i]),
         .ld      (ld),
         .ld_data (ld_data[i]),
         .q       (q[i]),
         .ill     (illegal_mask[i]),
         .ill_nxt (ill_nxt[i])
      );
   end
   // a new event outranks clr_err
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) illegal <= 1'b0;
      else        illegal <= ev ? 1'b1 : clr_err ? 1'b0 : illegal;
`ifdef FF_BANK_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_cnt <= '0;
      else        err_cnt <= ev ? (clr_err ? CNT_W'(1) : err_cnt + CNT_W'(~&err_cnt)) :
                             clr_err ? '0 : err_cnt;
`endif
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed and randomized checks of ff_bank against a per-bit reference model.
module tb_ff_bank;
   localparam int CMAX = 3;
   logic       clk = 0, rst_n, en, ld, clr_err;
   logic [1:0] mode;
   logic [7:0] a, b, ld_data, q, qbar, illegal_mask;
   logic       illegal;
   logic [1:0] err_cnt;
   logic [7:0] mq, mmask;
   logic       mill;
   int         mcnt;
   int         nchk = 0, npass = 0;

   always #5 clk = ~clk;

   ff_bank #(.WIDTH(8), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .ld(ld),
      .ld_data(ld_data), .clr_err(clr_err), .q(q), .qbar(qbar),
      .illegal_mask(illegal_mask), .illegal(illegal)
`ifdef FF_BANK_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );
`ifndef FF_BANK_ERR_CNT_EN
   assign err_cnt = '0;
`endif

   function automatic logic [7:0] model_q(logic [7:0] q0, logic [1:0] m, logic [7:0] av, logic [7:0] bv);
      logic [7:0] r = q0;
      for (int i = 0; i < 8; i++)
         case (m)
            2'd0: if (av[i] && !bv[i]) r[i] = 1'b1; else if (!av[i] && bv[i]) r[i] = 1'b0;
            2'd1: if (av[i] && bv[i]) r[i] = !q0[i]; else if (av[i]) r[i] = 1'b1; else if (bv[i]) r[i] = 1'b0;
            2'd2: r[i] = av[i];
            default: if (av[i]) r[i] = !q0[i];
         endcase
      return r;
   endfunction

   task automatic step(input logic e, input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                       input logic l, input logic [7:0] lv, input logic c);
      en = e; mode = m; a = av; b = bv; ld = l; ld_data = lv; clr_err = c;
      @(posedge clk);
      if (l) begin mq = lv; mmask = 8'h00; end
      else if (e) begin mmask = (m == 2'd0) ? (av & bv) : 8'h00; mq = model_q(mq, m, av, bv); end
      else mmask = 8'h00;
      if (mmask != 0) mill = 1'b1; else if (c) mill = 1'b0;
`ifdef FF_BANK_ERR_CNT_EN
      if (mmask != 0) mcnt = c ? 1 : (mcnt < CMAX ? mcnt + 1 : CMAX); else if (c) mcnt = 0;
`endif
      #1;
   endtask

   task automatic test_reset;
      rst_n = 0; en = 0; mode = 0; a = 0; b = 0; ld = 0; ld_data = 0; clr_err = 0;
      mq = 0; mmask = 0; mill = 0; mcnt = 0;
      #3;
      nchk++;
      if ({q, qbar, illegal_mask, illegal, err_cnt} !== {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0})
         $display("FAIL reset_init got q=%h qbar=%h mask=%h ill=%b cnt=%0d want 00 FF 00 0 0", q, qbar, illegal_mask, illegal, err_cnt);
      else npass++;
      @(posedge clk); #1 rst_n = 1;
      step(0, 0, 0, 0, 1, 8'hA5, 0);
      step(1, 0, 8'h01, 8'h01, 0, 0, 0);
      nchk++;
      if ({q, illegal_mask, illegal} !== {8'hA5, 8'h01, 1'b1})
         $display("FAIL pre_reset got q=%h mask=%h ill=%b want A5 01 1", q, illegal_mask, illegal);
      else npass++;
      #2 rst_n = 0;
      #1;
      nchk++;
      if ({q, qbar, illegal_mask, illegal, err_cnt} !== {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0})
         $display("FAIL reset_async got q=%h qbar=%h mask=%h ill=%b cnt=%0d want 00 FF 00 0 0", q, qbar, illegal_mask, illegal, err_cnt);
      else npass++;
      ld = 1; ld_data = 8'hFF; en = 1;
      @(posedge clk); #1;
      nchk++;
      if ({q, qbar} !== {8'h00, 8'hFF})
         $display("FAIL reset_override got q=%h qbar=%h want 00 FF", q, qbar);
      else npass++;
      rst_n = 1; ld = 0; en = 0;
      mq = 0; mmask = 0; mill = 0; mcnt = 0;
   endtask

   task automatic test_sr;
      step(1, 0, 8'h0F, 8'hF0, 0, 0, 0);
      nchk++;
      if ({q, illegal_mask, illegal} !== {8'h0F, 8'h00, 1'b0})
         $display("FAIL sr_set_clr got q=%h mask=%h ill=%b want 0F 00 0", q, illegal_mask, illegal);
      else npass++;
      step(1, 0, 8'h01, 8'h01, 0, 0, 0);
      nchk++;
      if ({q, qbar, illegal_mask, illegal} !== {8'h0F, 8'hF0, 8'h01, 1'b1})
         $display("FAIL sr_illegal got q=%h qbar=%h mask=%h ill=%b want 0F F0 01 1", q, qbar, illegal_mask, illegal);
      else npass++;
   endtask

   task automatic test_jk_t;
      step(0, 0, 0, 0, 0, 0, 1);
      nchk++;
      if ({q, illegal_mask, illegal} !== {8'h0F, 8'h00, 1'b0})
         $display("FAIL clr_alone got q=%h mask=%h ill=%b want 0F 00 0", q, illegal_mask, illegal);
      else npass++;
      step(1, 1, 8'hFF, 8'hFF, 0, 0, 0);
      nchk++;
      if ({q, illegal_mask, illegal} !== {8'hF0, 8'h00, 1'b0})
         $display("FAIL jk_toggle got q=%h mask=%h ill=%b want F0 00 0", q, illegal_mask, illegal);
      else npass++;
      step(1, 3, 8'h81, 8'h5A, 0, 0, 0);
      nchk++;
      if (q !== 8'h71) $display("FAIL t_toggle got q=%h want 71", q);
      else npass++;
      step(1, 2, 8'hC3, 8'hFF, 0, 0, 0);
      nchk++;
      if (q !== 8'hC3) $display("FAIL d_load got q=%h want C3", q);
      else npass++;
   endtask

   task automatic test_priority;
      step(1, 0, 8'h80, 8'h80, 0, 0, 0);
      step(1, 0, 8'hFF, 8'hFF, 1, 8'h3C, 0);
      nchk++;
      if ({q, illegal_mask, illegal} !== {8'h3C, 8'h00, 1'b1})
         $display("FAIL ld_priority got q=%h mask=%h ill=%b want 3C 00 1", q, illegal_mask, illegal);
      else npass++;
      step(1, 0, 8'h02, 8'h02, 0, 0, 1);
      nchk++;
      if ({illegal_mask, illegal} !== {8'h02, 1'b1})
         $display("FAIL clr_vs_event got mask=%h ill=%b want 02 1", illegal_mask, illegal);
      else npass++;
   endtask

   task automatic test_hold;
      logic [7:0] q0 = q;
      logic [1:0] c0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         step(0, 2'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);
         nchk++;
         if ({q, illegal_mask, err_cnt} !== {q0, 8'h00, c0})
            $display("FAIL hold_%0d got q=%h mask=%h cnt=%0d want %h 00 %0d", i, q, illegal_mask, err_cnt, q0, c0);
         else npass++;
      end
   endtask

`ifdef FF_BANK_ERR_CNT_EN
   task automatic test_counter;
      int exp_c [5] = '{1, 2, 3, 3, 3};
      step(0, 0, 0, 0, 0, 0, 1);
      nchk++;
      if (err_cnt !== 2'd0) $display("FAIL cnt_clear got %0d want 0", err_cnt);
      else npass++;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 8'($urandom) | 8'h10, 8'h18, 0, 0, 0);
         nchk++;
         if (err_cnt !== 2'(exp_c[i])) $display("FAIL cnt_sat_%0d got %0d want %0d", i, err_cnt, exp_c[i]);
         else npass++;
      end
      step(1, 0, 8'hFF, 8'hFF, 0, 0, 1);
      nchk++;
      if ({err_cnt, illegal} !== {2'd1, 1'b1}) $display("FAIL cnt_clr_event got cnt=%0d ill=%b want 1 1", err_cnt, illegal);
      else npass++;
      step(0, 0, 0, 0, 0, 0, 1);
      nchk++;
      if ({err_cnt, illegal} !== {2'd0, 1'b0}) $display("FAIL cnt_clr_alone got cnt=%0d ill=%b want 0 0", err_cnt, illegal);
      else npass++;
   endtask
`endif

   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(3) != 0, 2'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(7) == 0, 8'($urandom), $urandom_range(5) == 0);
         nchk++;
         if ({q, qbar, illegal_mask, illegal, err_cnt} !== {mq, ~mq, mmask, mill, 2'(mcnt)})
            $display("FAIL rand_%0d got q=%h qbar=%h mask=%h ill=%b cnt=%0d want %h %h %h %b %0d",
                     i, q, qbar, illegal_mask, illegal, err_cnt, mq, ~mq, mmask, mill, mcnt);
         else npass++;
      end
   endtask

   initial begin
      test_reset;
      test_sr;
      test_jk_t;
      test_priority;
      test_hold;
`ifdef FF_BANK_ERR_CNT_EN
      test_counter;
`endif
      test_random;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule

// File: doc/ff_bank.md
FF_BANK -- requirements
Module: ff_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of independent flip-flop channels (1..64).
REQ-002 SHALL provide parameter CNT_W, default 8, width of illegal-event counter (2..16).
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  per-cycle update enable for mode-driven updates.
REQ-006 SHALL have port mode  input  2  behaviour select: 0 SR, 1 JK, 2 D, 3 T.
REQ-007 SHALL have port a  input  WIDTH  per-channel S / J / D / T operand.
REQ-008 SHALL have port b  input  WIDTH  per-channel R / K operand; ignored in D and T modes.
REQ-009 SHALL have port ld  input  1  parallel load strobe.
REQ-010 SHALL have port ld_data  input  WIDTH  parallel load value.
REQ-011 SHALL have port clr_err  input  1  clears sticky flag and counter.
REQ-012 SHALL have port q  output  WIDTH  channel state.
REQ-013 SHALL have port qbar  output  WIDTH  complement of q.
REQ-014 SHALL have port illegal_mask  output  WIDTH  channels that saw S=R=1 in the previous cycle.
REQ-015 SHALL have port illegal  output  1  sticky any-illegal flag.
REQ-016 SHALL have port err_cnt  output  CNT_W  illegal-event count (present only with FF_BANK_ERR_CNT_EN).

Function
REQ-017 q SHALL update only on rising clk; priority: ld > en > hold.
REQ-018 ld=1 SHALL load q <= ld_data regardless of en and mode, with 1-cycle latency.
REQ-019 ld=0, en=0 SHALL hold q.
REQ-020 SR mode per bit: (a,b)=00 hold, 10 set, 01 clear, 11 hold and mark illegal.
REQ-021 JK mode per bit: 00 hold, 10 set, 01 clear, 11 toggle; never illegal.
REQ-022 D mode SHALL set q <= a; T mode SHALL toggle bits where a=1.
REQ-023 qbar SHALL equal ~q combinationally at all times, including during reset.
REQ-024 illegal_mask SHALL be registered each cycle as a&b when ld=0, en=1, mode=SR; otherwise 0.
REQ-025 illegal SHALL set on the edge on which any bit of the next illegal_mask is 1, and stay set until clr_err.
REQ-026 clr_err and a new illegal event in the same cycle: illegal SHALL end set (set wins).
REQ-027 Mode change SHALL take effect on the same edge, with no pipeline state kept across modes.

Reset
REQ-028 rst_n=0 SHALL immediately force q=0, qbar=all ones, illegal_mask=0, illegal=0, err_cnt=0, independent of clk.
REQ-029 Reset deassertion SHALL allow normal updates from the first rising edge after rst_n=1; assertion mid-operation overrides ld/en that cycle.

Configuration
REQ-030 With macro FF_BANK_ERR_CNT_EN defined, err_cnt SHALL increment by 1 per cycle containing >=1 illegal bit (not per bit), and SHALL saturate at 2^CNT_W-1.
REQ-031 With FF_BANK_ERR_CNT_EN, clr_err plus a simultaneous event SHALL yield err_cnt=1; clr_err alone SHALL yield 0.
REQ-032 Without FF_BANK_ERR_CNT_EN, the err_cnt port and counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-033 Package ff_bank_pkg SHALL hold mode encodings MODE_SR, MODE_JK, MODE_D, MODE_T and the 2-bit mode typedef.
REQ-034 Sub-module ff_cell SHALL implement one channel (next-state logic, ld, en, illegal bit); ff_bank SHALL instantiate WIDTH copies and own the flag and counter.

Verification
REQ-035 Reset: rst_n=0 mid-clock with q=8'hA5 -> q=8'h00 and qbar=8'hFF immediately, no clock edge needed.
REQ-036 SR mode, en=1: a=8'h0F, b=8'hF0 from q=8'h00 -> q=8'h0F; then a=8'h01, b=8'h01 -> q holds 8'h0F, illegal_mask=8'h01, illegal=1.
REQ-037 JK/T: q=8'h0F, JK a=b=8'hFF -> q=8'hF0; T a=8'h81 -> q=8'h71.
REQ-038 Priority: ld=1, ld_data=8'h3C, en=1, SR a=b=8'hFF -> q=8'h3C, illegal_mask=0, illegal unchanged.
REQ-039 Counter (macro on, CNT_W=2): 5 consecutive illegal cycles -> err_cnt=3 (saturated); clr_err with illegal event -> err_cnt=1, illegal=1.
REQ-040 en=0 for 4 cycles with random a/b/mode -> q, illegal_mask=0, and err_cnt unchanged.
